// File: rtl/pred_pkg.sv
// Shared types for the fetch-stage branch predictors.
//   br_type_e   : predecoded branch class carried with each fetch slot / retiring branch
//   ras_op_e    : operation applied to a return-address stack in one cycle
//   ras_entry_t : one return-address stack entry (link address + recursion count)
//   link_pc()   : return address of a call at the given PC
package pred_pkg;

    localparam int unsigned RAS_CNT_W = 8;

    typedef enum logic [2:0] {
        BR_NONE     = 3'b000,
        BR_DIRECT   = 3'b001,
        BR_CALL     = 3'b010,
        BR_RET      = 3'b011,
        BR_INDIRECT = 3'b100
    } br_type_e;

    typedef enum logic [1:0] {
        RAS_NONE = 2'b00,
        RAS_PUSH = 2'b01,
        RAS_POP  = 2'b10
    } ras_op_e;

    typedef struct packed {
        logic [31:0]          pc;
        logic [RAS_CNT_W-1:0] cnt;
    } ras_entry_t;

    // Call link address; wraps at 32 bits.
    function automatic logic [31:0] link_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with per-entry recursion counters.
//   clk, reset        : clock, synchronous active-high reset
//   op, push_pc       : push (with link address) / pop / none this cycle
//   load_en, load_st  : overwrite the whole state from load_st (wins over op)
//   top_pc_c/top_cnt_c: entry at the stack pointer
//   count             : number of live entries (0..DEPTH)
//   state_next_c      : full state as it will be after this cycle's update
// State bus layout, LSB first: DEPTH pcs, DEPTH counters, count, ptr.
module ras_stack
    import pred_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNTC_W = $clog2(DEPTH + 1),
    localparam int unsigned ST_W   = DEPTH * (32 + CNT_W) + CNTC_W + PTR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  ras_op_e           op,
    input  logic [31:0]       push_pc,
    input  logic              load_en,
    input  logic [ST_W-1:0]   load_st,
    output logic [31:0]       top_pc_c,
    output logic [CNT_W-1:0]  top_cnt_c,
    output logic [CNTC_W-1:0] count,
    output logic [ST_W-1:0]   state_next_c
);

    localparam int unsigned CNT_OFS   = DEPTH * 32;
    localparam int unsigned COUNT_OFS = DEPTH * (32 + CNT_W);
    localparam int unsigned PTR_OFS   = COUNT_OFS + CNTC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0]       pc_q  [DEPTH];
    logic [CNT_W-1:0]  cnt_q [DEPTH];
    logic [PTR_W-1:0]  ptr_q;
    logic [31:0]       pc_n  [DEPTH];
    logic [CNT_W-1:0]  cnt_n [DEPTH];
    logic [PTR_W-1:0]  ptr_n;
    logic [CNTC_W-1:0] count_n;

    assign top_pc_c  = pc_q[ptr_q];
    assign top_cnt_c = cnt_q[ptr_q];

    // Next-state: bulk load, or push/pop with recursion compression.
    always_comb begin
        pc_n         = pc_q;
        cnt_n        = cnt_q;
        ptr_n        = ptr_q;
        count_n      = count;
        state_next_c = '0;
        if (load_en) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_n[i]  = load_st[i*32 +: 32];
                cnt_n[i] = load_st[CNT_OFS + i*CNT_W +: CNT_W];
            end
            count_n = load_st[COUNT_OFS +: CNTC_W];
            ptr_n   = load_st[PTR_OFS +: PTR_W];
        end else begin
            case (op)
                RAS_PUSH: begin
                    // Repeated call to the same site only bumps the counter until it saturates.
                    if (count != '0 && top_pc_c == push_pc && top_cnt_c != CNT_MAX) begin
                        cnt_n[ptr_q] = CNT_W'(top_cnt_c + 1'b1);
                    end else begin
                        ptr_n        = PTR_W'(ptr_q + 1'b1);
                        pc_n[ptr_n]  = push_pc;
                        cnt_n[ptr_n] = CNT_W'(1);
                        if (count != CNTC_W'(DEPTH)) begin
                            count_n = CNTC_W'(count + 1'b1);
                        end
                    end
                end
                RAS_POP: begin
                    if (count != '0) begin
                        if (top_cnt_c > CNT_W'(1)) begin
                            cnt_n[ptr_q] = CNT_W'(top_cnt_c - 1'b1);
                        end else begin
                            cnt_n[ptr_q] = '0;
                            ptr_n        = PTR_W'(ptr_q - 1'b1);
                            count_n      = CNTC_W'(count - 1'b1);
                        end
                    end
                end
                default: ;
            endcase
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            state_next_c[i*32 +: 32]              = pc_n[i];
            state_next_c[CNT_OFS + i*CNT_W +: CNT_W] = cnt_n[i];
        end
        state_next_c[COUNT_OFS +: CNTC_W] = count_n;
        state_next_c[PTR_OFS +: PTR_W]    = ptr_n;
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_n;
            count <= count_n;
            pc_q  <= pc_n;
            cnt_q <= cnt_n;
        end
    end

endmodule

// File: rtl/ras_pred.sv
// Return-address-stack predictor: speculative stack updated at fetch,
// architectural stack updated at retire, flush copies arch into spec.
//   clk, reset                      : clock, synchronous active-high reset
//   fetch_valid/fetch_pc/fetch_type : fetch group (FETCH_W slots)
//   ret_valid/ret_slot/ret_target   : same-cycle return prediction
//   commit_valid/commit_pc/commit_type : one retiring branch
//   flush                           : mispredict; spec state <= post-commit arch state
module ras_pred
    import pred_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned FETCH_W = 2,
    localparam int unsigned SLOT_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_valid,
    input  logic [FETCH_W*32-1:0] fetch_pc,
    input  logic [FETCH_W*3-1:0] fetch_type,
    output logic                 ret_valid,
    output logic [SLOT_W-1:0]    ret_slot,
    output logic [31:0]          ret_target,
    input  logic                 commit_valid,
    input  logic [31:0]          commit_pc,
    input  logic [2:0]           commit_type,
    input  logic                 flush
);

    localparam int unsigned CNTC_W = $clog2(DEPTH + 1);
    localparam int unsigned ST_W   = DEPTH * (32 + CNT_W) + CNTC_W + $clog2(DEPTH);

    logic              sel_found;
    logic [SLOT_W-1:0] sel_slot;
    br_type_e          sel_type;
    logic [31:0]       sel_pc;
    ras_op_e           spec_op;
    ras_op_e           arch_op;

    logic [31:0]       spec_top_pc;
    logic [CNTC_W-1:0] spec_count;
    logic [ST_W-1:0]   arch_state_next;

    logic [CNT_W-1:0]  spec_top_cnt_unused;
    logic [ST_W-1:0]   spec_state_unused;
    logic [31:0]       arch_top_pc_unused;
    logic [CNT_W-1:0]  arch_top_cnt_unused;
    logic [CNTC_W-1:0] arch_count_unused;

    // Lowest-index call/ret slot wins; fetch redirects after it.
    always_comb begin
        sel_found = 1'b0;
        sel_slot  = '0;
        sel_type  = BR_NONE;
        sel_pc    = '0;
        for (int k = 0; k < int'(FETCH_W); k++) begin
            if (!sel_found && (br_type_e'(fetch_type[k*3 +: 3]) == BR_CALL ||
                               br_type_e'(fetch_type[k*3 +: 3]) == BR_RET)) begin
                sel_found = 1'b1;
                sel_slot  = SLOT_W'(k);
                sel_type  = br_type_e'(fetch_type[k*3 +: 3]);
                sel_pc    = fetch_pc[k*32 +: 32];
            end
        end
    end

    // Stack operations from fetch and retire.
    always_comb begin
        spec_op = RAS_NONE;
        arch_op = RAS_NONE;
        if (fetch_valid && sel_found) begin
            spec_op = (sel_type == BR_CALL) ? RAS_PUSH : RAS_POP;
        end
        if (commit_valid) begin
            if (br_type_e'(commit_type) == BR_CALL) begin
                arch_op = RAS_PUSH;
            end else if (br_type_e'(commit_type) == BR_RET) begin
                arch_op = RAS_POP;
            end
        end
    end

    // Prediction outputs; held at zero during reset.
    assign ret_valid  = !reset && fetch_valid && sel_found && sel_type == BR_RET && spec_count != '0;
    assign ret_slot   = reset ? '0 : sel_slot;
    assign ret_target = (reset || spec_count == '0) ? 32'd0 : spec_top_pc;

    ras_stack #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_spec (
        .clk          (clk),
        .reset        (reset),
        .op           (spec_op),
        .push_pc      (link_pc(sel_pc)),
        .load_en      (flush),
        .load_st      (arch_state_next),
        .top_pc_c     (spec_top_pc),
        .top_cnt_c    (spec_top_cnt_unused),
        .count        (spec_count),
        .state_next_c (spec_state_unused)
    );

    ras_stack #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_arch (
        .clk          (clk),
        .reset        (reset),
        .op           (arch_op),
        .push_pc      (link_pc(commit_pc)),
        .load_en      (1'b0),
        .load_st      ({ST_W{1'b0}}),
        .top_pc_c     (arch_top_pc_unused),
        .top_cnt_c    (arch_top_cnt_unused),
        .count        (arch_count_unused),
        .state_next_c (arch_state_next)
    );

endmodule

// File: tb/tb_ras_pred.sv
// Directed bench for ras_pred with hand-computed expected values.
module tb_ras_pred;
    import pred_pkg::*;

    localparam logic [2:0] N = 3'b000;
    localparam logic [2:0] C = 3'b010;
    localparam logic [2:0] R = 3'b011;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [63:0] fetch_pc;
    logic [5:0]  fetch_type;
    logic        ret_valid;
    logic [0:0]  ret_slot;
    logic [31:0] ret_target;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [2:0]  commit_type;
    logic        flush;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ras_pred dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_valid  (fetch_valid),
        .fetch_pc     (fetch_pc),
        .fetch_type   (fetch_type),
        .ret_valid    (ret_valid),
        .ret_slot     (ret_slot),
        .ret_target   (ret_target),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_type  (commit_type),
        .flush        (flush)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic v, input logic [2:0] t0, input logic [31:0] p0,
                         input logic [2:0] t1, input logic [31:0] p1);
        fetch_valid = v;
        fetch_type  = {t1, t0};
        fetch_pc    = {p1, p0};
        #1;
    endtask

    task automatic commit(input logic v, input logic [2:0] t, input logic [31:0] pc);
        commit_valid = v;
        commit_type  = t;
        commit_pc    = pc;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        commit(1'b0, N, 32'd0);
        fetch(1'b0, N, 32'd0, N, 32'd0);
        tick();
        tick();
        chk("rst_valid", 32'(ret_valid), 32'd0);
        chk("rst_target", ret_target, 32'd0);
        chk("rst_slot", 32'(ret_slot), 32'd0);
        reset = 1'b0;
        tick();

        // Ret on empty stack.
        fetch(1'b1, R, 32'h1c000000, N, 32'd0);
        chk("empty_ret_valid", 32'(ret_valid), 32'd0);
        chk("empty_ret_target", ret_target, 32'd0);
        chk("empty_ret_slot", 32'(ret_slot), 32'd0);
        tick();

        // Call in slot 1, then ret in slot 1.
        fetch(1'b1, N, 32'h1c0000fc, C, 32'h1c000100);
        chk("call1_slot", 32'(ret_slot), 32'd1);
        chk("call1_valid", 32'(ret_valid), 32'd0);
        tick();
        fetch(1'b1, N, 32'h1c000300, R, 32'h1c000304);
        chk("ret1_valid", 32'(ret_valid), 32'd1);
        chk("ret1_slot", 32'(ret_slot), 32'd1);
        chk("ret1_target", ret_target, 32'h1c000104);
        tick();
        fetch(1'b1, R, 32'h1c000400, N, 32'd0);
        chk("ret1_after_valid", 32'(ret_valid), 32'd0);
        tick();

        // Recursion: three calls from the same site compress into one entry.
        for (int i = 0; i < 3; i++) begin
            fetch(1'b1, C, 32'h1c000200, N, 32'd0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            fetch(1'b1, R, 32'h1c000500, N, 32'd0);
            chk("rec_valid", 32'(ret_valid), 32'd1);
            chk("rec_target", ret_target, 32'h1c000204);
            tick();
        end
        fetch(1'b1, R, 32'h1c000500, N, 32'd0);
        chk("rec_empty_valid", 32'(ret_valid), 32'd0);
        tick();

        // Counter saturation: 255 compressed calls, the 256th pushes a new entry.
        for (int i = 0; i < 256; i++) begin
            fetch(1'b1, C, 32'h1c000300, N, 32'd0);
            tick();
        end
        for (int i = 0; i < 256; i++) begin
            fetch(1'b1, R, 32'h1c000600, N, 32'd0);
            chk("sat_valid", 32'(ret_valid), 32'd1);
            chk("sat_target", ret_target, 32'h1c000304);
            tick();
        end
        fetch(1'b1, R, 32'h1c000600, N, 32'd0);
        chk("sat_empty_valid", 32'(ret_valid), 32'd0);
        tick();

        // Overflow: DEPTH+1 distinct calls, oldest overwritten.
        for (int i = 0; i < 17; i++) begin
            fetch(1'b1, C, 32'h1000 + 32'(16 * i), N, 32'd0);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            fetch(1'b1, R, 32'h9000, N, 32'd0);
            chk("ovf_valid", 32'(ret_valid), 32'd1);
            chk("ovf_target", ret_target, 32'h1004 + 32'(16 * (16 - i)));
            tick();
        end
        fetch(1'b1, R, 32'h9000, N, 32'd0);
        chk("ovf_empty_valid", 32'(ret_valid), 32'd0);
        chk("ovf_empty_target", ret_target, 32'd0);
        tick();

        // Flush restores the committed stack.
        commit(1'b1, C, 32'h2000);
        fetch(1'b0, N, 32'd0, N, 32'd0);
        tick();
        commit(1'b0, N, 32'd0);
        fetch(1'b1, C, 32'h3000, N, 32'd0);
        tick();
        fetch(1'b1, R, 32'h3100, N, 32'd0);
        chk("bogus_ret_target", ret_target, 32'h3004);
        tick();
        fetch(1'b1, C, 32'h3000, N, 32'd0);
        tick();
        flush = 1'b1;
        fetch(1'b1, C, 32'h3200, N, 32'd0);
        chk("pre_flush_target", ret_target, 32'h3004);
        tick();
        flush = 1'b0;
        fetch(1'b0, N, 32'd0, N, 32'd0);
        chk("flush_target", ret_target, 32'h2004);
        chk("flush_idle_valid", 32'(ret_valid), 32'd0);
        fetch(1'b1, R, 32'h3300, N, 32'd0);
        chk("flush_ret_valid", 32'(ret_valid), 32'd1);
        tick();

        // Flush together with a committing ret uses the post-commit state.
        commit(1'b1, R, 32'h2abc);
        flush = 1'b1;
        fetch(1'b0, N, 32'd0, N, 32'd0);
        tick();
        commit(1'b0, N, 32'd0);
        flush = 1'b0;
        fetch(1'b1, R, 32'h3400, N, 32'd0);
        chk("flush_commit_valid", 32'(ret_valid), 32'd0);
        chk("flush_commit_target", ret_target, 32'd0);
        tick();

        // Ret in slot 0 shadows a call in slot 1.
        fetch(1'b1, C, 32'h4000, N, 32'd0);
        tick();
        fetch(1'b1, R, 32'h4100, C, 32'h5000);
        chk("slot0_valid", 32'(ret_valid), 32'd1);
        chk("slot0_slot", 32'(ret_slot), 32'd0);
        chk("slot0_target", ret_target, 32'h4004);
        tick();
        fetch(1'b0, N, 32'd0, N, 32'd0);
        chk("slot1_ignored_target", ret_target, 32'd0);

        // Reset wins over fetch and commit.
        fetch(1'b1, C, 32'h6000, N, 32'd0);
        tick();
        fetch(1'b0, N, 32'd0, N, 32'd0);
        chk("pre_reset_target", ret_target, 32'h6004);
        reset = 1'b1;
        commit(1'b1, C, 32'h7100);
        fetch(1'b1, C, 32'h7000, N, 32'd0);
        tick();
        reset = 1'b0;
        commit(1'b0, N, 32'd0);
        fetch(1'b0, N, 32'd0, N, 32'd0);
        chk("post_reset_target", ret_target, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("post_reset_flush_target", ret_target, 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/ras_pred.md
Name: ras_pred

Overview:
- Parametrised return-address-stack predictor for the fetch stage, sitting beside the BHT/PHT/target-cache predictor.
- Supplies return targets for `ret` instructions (type 011) using per-entry recursion counters.
- Keeps a speculative stack (updated at fetch) and an architectural stack (updated at retire). A mispredict flush restores speculative state in one cycle.
- Predictor top-level muxes ret_target into ret_pc_x in place of the target-cache result when ret_valid=1.

Parameters:
- DEPTH, 16, number of stack entries (power of 2, ≥2).
- CNT_W, 8, recursion counter width; max value = 2**CNT_W-1.
- FETCH_W, 2, instruction slots per fetch group.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- fetch_valid  in  1  fetch group accepted this cycle.
- fetch_pc  in  FETCH_W*32  slot PCs; slot k at [32k+31:32k].
- fetch_type  in  FETCH_W*3  predecoded br_type_e per slot.
- ret_valid  out  1  stack non-empty and the selected slot is a ret.
- ret_slot  out  $clog2(FETCH_W) (min 1)  index of the selected call/ret slot.
- ret_target  out  32  top-of-stack address; 0 when empty.
- commit_valid  in  1  one branch retires.
- commit_pc  in  32  retiring PC.
- commit_type  in  3  retiring br_type_e.
- flush  in  1  branch_mistaken; copy architectural state into speculative state.

Behaviour:
- Type encoding:
  - 000 none, 001 direct, 010 call, 011 ret, 100 indirect.
  - Only the lowest-index slot with type 010 or 011 is processed per group. Later slots are ignored, because fetch redirects after a taken call/ret.
- Read path:
  - Combinational, same cycle as fetch. ret_target = spec top entry.
  - ret_valid = fetch_valid & selected type==011 & spec_count!=0.
- Call (push):
  - link = slot pc+4 (32-bit wrap).
  - If count!=0, top==link and top counter != max: increment top counter only.
  - Otherwise ptr+1 (mod DEPTH), write {link, cnt=1}, count=min(count+1, DEPTH).
  - Full stack: the oldest entry is overwritten circularly; count stays DEPTH.
- Ret (pop):
  - Empty (count==0): no state change, ret_valid=0.
  - Top counter >1: decrement the counter.
  - Otherwise: clear the counter, ptr-1 (mod DEPTH), count-1.
- Timing: the state effect of push/pop is visible on the next cycle.
- Architectural stack: applies the identical push/pop rules with commit_pc/commit_type when commit_valid.
- Flush:
  - Next cycle spec state = arch state, including any commit in the same cycle (post-commit value).
  - The fetch op in the flush cycle is discarded.
- Reset:
  - Both stacks: ptr=0, count=0, all counters=0, entry PCs=0.
  - Outputs at reset: ret_valid=0, ret_target=0, ret_slot=0.
  - Reset wins over flush, commit and fetch.
- No handshake back-pressure: the block always accepts; the caller gates with fetch_valid/commit_valid.

Decomposition:
- pred_pkg holds:
  - typedef enum logic[2:0] br_type_e {BR_NONE, BR_DIRECT, BR_CALL, BR_RET, BR_INDIRECT};
  - typedef struct ras_entry_t {pc[31:0], cnt[CNT_W-1:0]};
  - helper function link_pc(pc).
- Sub-module ras_stack, instantiated twice (spec, arch):
  - Inputs: op push/pop/none, push_pc, load_en, load bus carrying the full state.
  - Outputs: top entry, count, full state bus.
- ras_pred does slot selection, read output and flush wiring.

Test Plan:
- Reset, then fetch ret at slot 0 → ret_valid=0, ret_target=0, no pointer change.
- Call at pc 0x1c000100 slot 1 (slot 0 type 000), next cycle ret → ret_valid=1, ret_slot=1, ret_target=0x1c000104; the following ret → ret_valid=0.
- Three calls from pc 0x1c000200, then three rets → count stays 1 with cnt=3; rets return 0x1c000204 each time; fourth ret → ret_valid=0. Also saturate at cnt=255, then one more call → new entry pushed.
- DEPTH+1 distinct calls (0x1000+0x10*i) → count=16; 16 rets return the last 16 links in LIFO order; the 17th ret → empty.
- Commit call 0x2000; spec receives a bogus call 0x3000 and a ret; assert flush → next cycle ret_target=0x2004.
- Flush and commit ret in the same cycle with arch holding 0x2004 → spec becomes empty afterwards.
- Fetch with slot0=ret and slot1=call → only the ret pops; the call is ignored.
